// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program-counter unit with stall, halt/resume, EPC capture and optional return stack
//
// Optional feature macro: PC_RAS_EN (return-address stack of RAS_DEPTH entries)
//
// Ports:
//   clock            system clock; all state updates on the falling edge
//   reset            asynchronous active-low reset
//   stall            hold pc this cycle
//   redirect         load redirect_target (word-aligned) as next pc
//   redirect_target  branch/jump destination
//   exc              exception request: save pc to epc, jump to exception vector
//   eret             return from exception to epc
//   halt_req         enter HALT
//   resume           leave HALT
//   call / ret       call / return hints for the return stack
//   pc               current fetch address
//   fetch_valid      pc is a valid fetch this cycle
//   epc              saved exception pc
//   misaligned       one-cycle pulse when the accepted redirect target had low bits set
//   ras_top          predicted return address (0 when the stack is empty or absent)
//   ras_empty        return stack empty
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h00000180,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc,
  input  logic             eret,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] epc,
  output logic             misaligned,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty
);

  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] STEP   = WIDTH'(INC);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc_seq;

  // Sequential successor; wraps modulo 2^WIDTH.
  assign pc_seq = pc + STEP;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      epc         <= '0;
      misaligned  <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      // misaligned is a pulse: only an accepted redirect can raise it.
      misaligned <= 1'b0;
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (exc) begin
            epc <= pc;
            pc  <= EXC_PC;
          end else if (eret) begin
            pc <= epc;
          end else if (redirect) begin
            pc         <= {redirect_target[WIDTH-1:2], 2'b00};
            misaligned <= |redirect_target[1:0];
          end else if (halt_req) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
          end else if (!stall) begin
            pc <= pc_seq;
          end
        end
        HALT: begin
          // Only an exception or resume wakes the core; everything else is dropped.
          if (exc) begin
            epc         <= pc;
            pc          <= EXC_PC;
            state       <= RUN;
            fetch_valid <= 1'b1;
          end else if (resume) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;      // next free slot; top lives at ras_ptr-1
  logic [CW-1:0]    ras_cnt;      // saturating occupancy
  logic [PW-1:0]    ras_top_idx;
  logic             ras_run;
  logic             ras_push;
  logic             ras_replace;
  logic             ras_pop;

  assign ras_top_idx = ras_ptr - PW'(1);
  assign ras_run     = (state == RUN) && !exc;
  // call+ret on an empty stack behaves as a push so the return address is not lost.
  assign ras_push    = ras_run && call && (!ret || (ras_cnt == '0));
  assign ras_replace = ras_run && call && ret && (ras_cnt != '0);
  assign ras_pop     = ras_run && ret && !call && (ras_cnt != '0);

  always_ff @(negedge clock) begin
    if (ras_push) begin
      ras_mem[ras_ptr] <= pc_seq;
    end else if (ras_replace) begin
      ras_mem[ras_top_idx] <= pc_seq;
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if ((state == RUN) && exc) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      // Circular: a push when full silently overwrites the oldest entry.
      ras_ptr <= ras_ptr + PW'(1);
      if (ras_cnt != CW'(RAS_DEPTH)) begin
        ras_cnt <= ras_cnt + CW'(1);
      end
    end else if (ras_pop) begin
      ras_ptr <= ras_top_idx;
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_empty ? '0 : ras_mem[ras_top_idx];
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_hints;
  assign unused_ras_hints = &{1'b0, call, ret};
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
`endif

endmodule
